// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: E-register bank, EX/MEM and MEM/WB forwarding, load-use stall/bubble.
// Optional OPERAND_A_PC_EN adds ALUSrcAD so operand A can select PCE (auipc).
module ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCD,
    input  logic [REGW-1:0] Rs1D,
    input  logic [REGW-1:0] Rs2D,
    input  logic [REGW-1:0] RdD,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            BranchD,
    input  logic            JumpD,
    input  logic            ALUSrcD,
    input  logic [1:0]      ResultSrcD,
    input  logic [3:0]      ALUControlD,
`ifdef OPERAND_A_PC_EN
    input  logic            ALUSrcAD,
`endif
    input  logic            FlushE,
    input  logic [REGW-1:0] RdM,
    input  logic [REGW-1:0] RdW,
    input  logic            RegWriteM,
    input  logic            RegWriteW,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] ResultW,
    output logic [XLEN-1:0] SourceAE,
    output logic [XLEN-1:0] SourceBE,
    output logic [XLEN-1:0] WriteDataE,
    output logic [3:0]      ALUControlE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            BranchE,
    output logic            JumpE,
    output logic [1:0]      ResultSrcE,
    output logic [REGW-1:0] RdE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] ImmExtE,
    output logic            StallF,
    output logic            StallD
);

    logic [XLEN-1:0] RD1E, RD2E;
    logic [REGW-1:0] Rs1E, Rs2E;
    logic            ALUSrcE;
    logic            lwStall;
    logic [XLEN-1:0] opA, opB;
`ifdef OPERAND_A_PC_EN
    logic            ALUSrcAE;
`endif

    assign lwStall = (ResultSrcE == 2'b01) && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign StallF  = lwStall;
    assign StallD  = lwStall;

    // Bubbles clear the data registers too, so every data-driven output reads 0 without extra masking.
    always_ff @(posedge clk) begin
        if (!rst_n || FlushE || lwStall) begin
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            BranchE     <= 1'b0;
            JumpE       <= 1'b0;
            ALUSrcE     <= 1'b0;
            ResultSrcE  <= '0;
            ALUControlE <= '0;
            Rs1E        <= '0;
            Rs2E        <= '0;
            RdE         <= '0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            PCE         <= '0;
`ifdef OPERAND_A_PC_EN
            ALUSrcAE    <= 1'b0;
`endif
        end else begin
            RegWriteE   <= RegWriteD;
            MemWriteE   <= MemWriteD;
            BranchE     <= BranchD;
            JumpE       <= JumpD;
            ALUSrcE     <= ALUSrcD;
            ResultSrcE  <= ResultSrcD;
            ALUControlE <= ALUControlD;
            Rs1E        <= Rs1D;
            Rs2E        <= Rs2D;
            RdE         <= RdD;
            RD1E        <= RD1D;
            RD2E        <= RD2D;
            ImmExtE     <= ImmExtD;
            PCE         <= PCD;
`ifdef OPERAND_A_PC_EN
            ALUSrcAE    <= ALUSrcAD;
`endif
        end
    end

    // MEM result is younger than WB, so it wins; x0 is never forwarded.
    always_comb begin
        opA = RD1E;
        if (RegWriteM && (RdM != '0) && (RdM == Rs1E))
            opA = ALUResultM;
        else if (RegWriteW && (RdW != '0) && (RdW == Rs1E))
            opA = ResultW;
    end

    always_comb begin
        opB = RD2E;
        if (RegWriteM && (RdM != '0) && (RdM == Rs2E))
            opB = ALUResultM;
        else if (RegWriteW && (RdW != '0) && (RdW == Rs2E))
            opB = ResultW;
    end

`ifdef OPERAND_A_PC_EN
    assign SourceAE = ALUSrcAE ? PCE : opA;
`else
    assign SourceAE = opA;
`endif
    assign WriteDataE = opB;
    assign SourceBE   = ALUSrcE ? ImmExtE : opB;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed scenarios plus randomized traffic vs. a record-level model.
module tb_ex_operand_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] RD1D, RD2D, ImmExtD, PCD;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic        RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD;
    logic [1:0]  ResultSrcD;
    logic [3:0]  ALUControlD;
`ifdef OPERAND_A_PC_EN
    logic        ALUSrcAD;
`endif
    logic        FlushE;
    logic [4:0]  RdM, RdW;
    logic        RegWriteM, RegWriteW;
    logic [31:0] ALUResultM, ResultW;
    logic [31:0] SourceAE, SourceBE, WriteDataE, PCE, ImmExtE;
    logic [3:0]  ALUControlE;
    logic        RegWriteE, MemWriteE, BranchE, JumpE;
    logic [1:0]  ResultSrcE;
    logic [4:0]  RdE;
    logic        StallF, StallD;

    int checks = 0;
    int errors = 0;

    ex_operand_stage #(.XLEN(32), .REGW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .BranchD(BranchD),
        .JumpD(JumpD), .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD),
        .ALUControlD(ALUControlD),
`ifdef OPERAND_A_PC_EN
        .ALUSrcAD(ALUSrcAD),
`endif
        .FlushE(FlushE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ALUResultM(ALUResultM), .ResultW(ResultW),
        .SourceAE(SourceAE), .SourceBE(SourceBE), .WriteDataE(WriteDataE),
        .ALUControlE(ALUControlE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .BranchE(BranchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE), .RdE(RdE),
        .PCE(PCE), .ImmExtE(ImmExtE), .StallF(StallF), .StallD(StallD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the instruction record currently sitting in EX (all-zero = bubble).
    typedef struct packed {
        logic        rw, mw, br, jp, asrc, asrca;
        logic [1:0]  rsrc;
        logic [3:0]  alu;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rd1, rd2, imm, pc;
    } erec_t;

    erec_t m;
    logic  held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf);
        if (RegWriteM && RdM != 0 && RdM == idx) return ALUResultM;
        if (RegWriteW && RdW != 0 && RdW == idx) return ResultW;
        return rf;
    endfunction

    // Compare all outputs against the model, then advance the model across one clock edge.
    task automatic tick();
        logic [31:0] ea, eb, ewd;
        logic        st;
        #1;
        st  = (m.rsrc == 2'b01) && (m.rd != 0) && (m.rd == Rs1D || m.rd == Rs2D);
        ea  = fwd(m.rs1, m.rd1);
`ifdef OPERAND_A_PC_EN
        if (m.asrca) ea = m.pc;
`endif
        ewd = fwd(m.rs2, m.rd2);
        eb  = m.asrc ? m.imm : ewd;
        chk("SourceAE", SourceAE, ea);
        chk("SourceBE", SourceBE, eb);
        chk("WriteDataE", WriteDataE, ewd);
        chk("ALUControlE", {28'd0, ALUControlE}, {28'd0, m.alu});
        chk("RegWriteE", {31'd0, RegWriteE}, {31'd0, m.rw});
        chk("MemWriteE", {31'd0, MemWriteE}, {31'd0, m.mw});
        chk("BranchE", {31'd0, BranchE}, {31'd0, m.br});
        chk("JumpE", {31'd0, JumpE}, {31'd0, m.jp});
        chk("ResultSrcE", {30'd0, ResultSrcE}, {30'd0, m.rsrc});
        chk("RdE", {27'd0, RdE}, {27'd0, m.rd});
        chk("PCE", PCE, m.pc);
        chk("ImmExtE", ImmExtE, m.imm);
        chk("StallF", {31'd0, StallF}, {31'd0, st});
        chk("StallD", {31'd0, StallD}, {31'd0, st});
        @(posedge clk);
        if (!rst_n || FlushE || st) begin
            m = '0;
        end else begin
            m.rw = RegWriteD; m.mw = MemWriteD; m.br = BranchD; m.jp = JumpD;
            m.asrc = ALUSrcD; m.rsrc = ResultSrcD; m.alu = ALUControlD;
            m.rs1 = Rs1D; m.rs2 = Rs2D; m.rd = RdD;
            m.rd1 = RD1D; m.rd2 = RD2D; m.imm = ImmExtD; m.pc = PCD;
`ifdef OPERAND_A_PC_EN
            m.asrca = ALUSrcAD;
`else
            m.asrca = 1'b0;
`endif
        end
        held = st;
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        RD1D = 0; RD2D = 0; ImmExtD = 0; PCD = 0;
        Rs1D = 0; Rs2D = 0; RdD = 0;
        RegWriteD = 0; MemWriteD = 0; BranchD = 0; JumpD = 0; ALUSrcD = 0;
        ResultSrcD = 0; ALUControlD = 0;
`ifdef OPERAND_A_PC_EN
        ALUSrcAD = 0;
`endif
        FlushE = 0; RdM = 0; RdW = 0; RegWriteM = 0; RegWriteW = 0;
        ALUResultM = 0; ResultW = 0;
    endtask

    task automatic rand_d();
        RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom; PCD = $urandom;
        Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7));
        RdD = 5'($urandom_range(0, 7));
        RegWriteD = 1'($urandom); MemWriteD = 1'($urandom);
        BranchD = 1'($urandom); JumpD = 1'($urandom); ALUSrcD = 1'($urandom);
        ResultSrcD = 2'($urandom_range(0, 3)); ALUControlD = 4'($urandom);
`ifdef OPERAND_A_PC_EN
        ALUSrcAD = 1'($urandom);
`endif
    endtask

    task automatic rand_mw();
        RdM = 5'($urandom_range(0, 7)); RdW = 5'($urandom_range(0, 7));
        RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
        ALUResultM = $urandom; ResultW = $urandom;
    endtask

    initial begin
        m = '0;
        held = 1'b0;
        clear_inputs();
        rst_n = 1'b0;
        rand_d();
        RegWriteD = 1'b1; Rs1D = 5'd3; RdD = 5'd4; RD1D = 32'h1234_5678;

        // Reset held for two edges with nonzero D inputs.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_SourceAE", SourceAE, 32'h0);
        chk("reset_RegWriteE", {31'd0, RegWriteE}, 32'h0);
        chk("reset_StallD", {31'd0, StallD}, 32'h0);
        chk("reset_PCE", PCE, 32'h0);
        tick();

        // add x5,x3,x4 into EX, then MEM vs WB forwarding of x3.
        clear_inputs();
        rst_n = 1'b1;
        Rs1D = 5'd3; Rs2D = 5'd4; RdD = 5'd5; RegWriteD = 1'b1;
        RD1D = 32'h11; RD2D = 32'h22;
        tick();
        clear_inputs();
        RegWriteM = 1'b1; RdM = 5'd3; ALUResultM = 32'h0000_00AA;
        RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h0000_0055;
        #1;
        chk("fwd_mem_wins", SourceAE, 32'h0000_00AA);
        RdM = 5'd0;
        #1;
        chk("fwd_wb_when_rdm0", SourceAE, 32'h0000_0055);
        chk("fwd_none_B", SourceBE, 32'h22);
        tick();

        // Load-use: lw x7 in EX, dependent add x8,x2,x7 in D.
        clear_inputs();
        RdD = 5'd7; RegWriteD = 1'b1; ResultSrcD = 2'b01; Rs1D = 5'd1;
        tick();
        clear_inputs();
        Rs1D = 5'd2; Rs2D = 5'd7; RdD = 5'd8; RegWriteD = 1'b1; RD2D = 32'h999;
        #1;
        chk("lu_StallF", {31'd0, StallF}, 32'h1);
        chk("lu_StallD", {31'd0, StallD}, 32'h1);
        tick();
        #1;
        chk("lu_bubble_RegWriteE", {31'd0, RegWriteE}, 32'h0);
        chk("lu_bubble_MemWriteE", {31'd0, MemWriteE}, 32'h0);
        chk("lu_bubble_RdE", {27'd0, RdE}, 32'h0);
        chk("lu_stall_one_cycle", {31'd0, StallD}, 32'h0);
        tick();
        RegWriteW = 1'b1; RdW = 5'd7; ResultW = 32'h0000_1234;
        #1;
        chk("lu_RdE", {27'd0, RdE}, 32'h8);
        chk("lu_wb_fwd_B", SourceBE, 32'h0000_1234);
        tick();

        // Immediate select on B while rs2 is forwarded from MEM onto WriteDataE.
        clear_inputs();
        ALUSrcD = 1'b1; ImmExtD = 32'hFFFF_FFF0; Rs2D = 5'd6; RD2D = 32'h77;
        tick();
        clear_inputs();
        RegWriteM = 1'b1; RdM = 5'd6; ALUResultM = 32'h0000_CAFE;
        #1;
        chk("imm_SourceBE", SourceBE, 32'hFFFF_FFF0);
        chk("imm_WriteDataE", WriteDataE, 32'h0000_CAFE);
        tick();

        // Flush alongside a valid store.
        clear_inputs();
        MemWriteD = 1'b1; RegWriteD = 1'b1; BranchD = 1'b1; JumpD = 1'b1;
        Rs1D = 5'd1; Rs2D = 5'd2; PCD = 32'h40; RD1D = 32'h5;
        FlushE = 1'b1;
        tick();
        clear_inputs();
        #1;
        chk("flush_MemWriteE", {31'd0, MemWriteE}, 32'h0);
        chk("flush_RegWriteE", {31'd0, RegWriteE}, 32'h0);
        chk("flush_BranchE", {31'd0, BranchE}, 32'h0);
        chk("flush_JumpE", {31'd0, JumpE}, 32'h0);
        chk("flush_PCE", PCE, 32'h0);
        tick();

        // Reset arriving during a load-use stall.
        clear_inputs();
        RdD = 5'd9; RegWriteD = 1'b1; ResultSrcD = 2'b01;
        tick();
        clear_inputs();
        Rs1D = 5'd9; RdD = 5'd10; RegWriteD = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mr_StallD_before", {31'd0, StallD}, 32'h1);
        tick();
        #1;
        chk("mr_RegWriteE", {31'd0, RegWriteE}, 32'h0);
        chk("mr_RdE", {27'd0, RdE}, 32'h0);
        chk("mr_ResultSrcE", {30'd0, ResultSrcE}, 32'h0);
        chk("mr_StallD", {31'd0, StallD}, 32'h0);
        clear_inputs();
        rst_n = 1'b1;
        PCD = 32'h100; RD1D = 32'h3;
`ifdef OPERAND_A_PC_EN
        ALUSrcAD = 1'b1;
`endif
        tick();
        #1;
`ifdef OPERAND_A_PC_EN
        chk("pc_SourceAE", SourceAE, 32'h100);
`else
        chk("opA_SourceAE", SourceAE, 32'h3);
`endif
        tick();

        // Randomized traffic; D is held upstream whenever the stage requested a stall.
        held = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!held) rand_d();
            rand_mw();
            FlushE = ($urandom_range(0, 9) == 0);
            rst_n  = ($urandom_range(0, 39) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
